// File: rtl/sprite_defs.sv
// Shared definitions for the sprite motion engine: table entry layout,
// FSM encoding and velocity-byte field helpers.
package sprite_defs;

   localparam logic [1:0] OFS_X    = 2'd0;
   localparam logic [1:0] OFS_Y    = 2'd1;
   localparam logic [1:0] OFS_ATTR = 2'd2;
   localparam logic [1:0] OFS_VEL  = 2'd3;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   // vel byte: dx in the high nibble, dy in the low nibble, both signed 4-bit
   function automatic logic [3:0] vel_dx(input logic [7:0] v);
      return v[7:4];
   endfunction

   function automatic logic [3:0] vel_dy(input logic [7:0] v);
      return v[3:0];
   endfunction

   function automatic logic [7:0] vel_pack(input logic [3:0] dx, input logic [3:0] dy);
      return {dx, dy};
   endfunction

endpackage

// File: rtl/sprite_motion_engine_if.sv
// Engine-side control handshake plus the shared sprite RAM port.
interface sprite_motion_engine_if #(parameter int NB = 5);
   logic          start;
   logic          busy;
   logic          done;
   logic [NB+1:0] ram_addr;
   logic [7:0]    ram_din;
   logic [7:0]    ram_dout;
   logic          ram_we;

   modport master (input start, ram_din,
                   output busy, done, ram_addr, ram_dout, ram_we);
   modport slave  (output start, ram_din,
                   input busy, done, ram_addr, ram_dout, ram_we);
endinterface

// File: rtl/sprite_axis_step.sv
// One axis of sprite motion: add signed velocity, clamp to [lo, hi] and
// reflect the velocity on a clamp. Purely combinational.
module sprite_axis_step (
   input  logic [7:0] pos,
   input  logic [3:0] d,
   input  logic [7:0] lo,
   input  logic [7:0] hi,
   output logic [7:0] pos_nx,
   output logic [3:0] d_nx
);
   logic signed [9:0] sum;
   logic [3:0]        d_neg;

   always_comb begin
      // 10-bit signed so a step past 0 or 255 can never wrap
      sum    = $signed({2'b00, pos}) + $signed({{6{d[3]}}, d});
      d_neg  = (d == 4'h8) ? 4'h7 : (~d + 4'd1);
      pos_nx = sum[7:0];
      d_nx   = d;
      if (sum > $signed({2'b00, hi})) begin
         pos_nx = hi;
         d_nx   = d_neg;
      end else if (sum < $signed({2'b00, lo})) begin
         pos_nx = lo;
         d_nx   = d_neg;
      end
   end
endmodule

// File: rtl/sprite_motion_engine.sv
// Per-frame sprite mover: walks the sprite table once per start pulse,
// 8 cycles per entry (3 reads, compute, 3 writes), then pulses done.
module sprite_motion_engine
   import sprite_defs::*;
#(
   parameter int         NB   = 5,
   parameter logic [7:0] XMIN = 8'd0,
   parameter logic [7:0] XMAX = 8'd240,
   parameter logic [7:0] YMIN = 8'd0,
   parameter logic [7:0] YMAX = 8'd240
) (
   input  logic clk,
   input  logic reset,
   sprite_motion_engine_if.master bus
);
   state_t        state, state_nx;
   logic [2:0]    phase, phase_nx;
   logic [NB-1:0] index, index_nx;
   logic [7:0]    cap_x, cap_y, cap_vel, new_y, new_vel;
   logic          busy_q, done_q, we_q, busy_nx, done_nx, we_nx;
   logic [NB+1:0] addr_q, addr_nx;
   logic [7:0]    dout_q, dout_nx;
   logic [1:0]    ofs;

   // axis 0 = X, axis 1 = Y
   logic [1:0][7:0] ax_pos, ax_lo, ax_hi, ax_pos_nx;
   logic [1:0][3:0] ax_d, ax_d_nx;

   assign ax_pos = {cap_y, cap_x};
   assign ax_d   = {vel_dy(cap_vel), vel_dx(cap_vel)};
   assign ax_lo  = {YMIN, XMIN};
   assign ax_hi  = {YMAX, XMAX};

   for (genvar a = 0; a < 2; a++) begin : g_axis
      sprite_axis_step u_step (
         .pos    (ax_pos[a]),
         .d      (ax_d[a]),
         .lo     (ax_lo[a]),
         .hi     (ax_hi[a]),
         .pos_nx (ax_pos_nx[a]),
         .d_nx   (ax_d_nx[a])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         phase   <= '0;
         index   <= '0;
         cap_x   <= '0;
         cap_y   <= '0;
         cap_vel <= '0;
         new_y   <= '0;
         new_vel <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
      end else begin
         state  <= state_nx;
         phase  <= phase_nx;
         index  <= index_nx;
         busy_q <= busy_nx;
         done_q <= done_nx;
         we_q   <= we_nx;
         addr_q <= addr_nx;
         dout_q <= dout_nx;
         // ram_din carries the data addressed one cycle earlier
         if (state == ST_RUN) begin
            case (phase)
               3'd1: cap_x   <= bus.ram_din;
               3'd2: cap_y   <= bus.ram_din;
               3'd3: cap_vel <= bus.ram_din;
               3'd4: begin
                  new_y   <= ax_pos_nx[1];
                  new_vel <= vel_pack(ax_d_nx[0], ax_d_nx[1]);
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nx = state;
      phase_nx = phase;
      index_nx = index;
      case (state)
         ST_IDLE: if (bus.start) begin
            state_nx = ST_RUN;
            phase_nx = '0;
            index_nx = '0;
         end
         ST_RUN: begin
            phase_nx = phase + 3'd1;
            if (phase == 3'd7) begin
               index_nx = index + 1'b1;
               if (index == {NB{1'b1}}) state_nx = ST_DONE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // RAM outputs are registered, so they are decoded from the next phase
   always_comb begin
      busy_nx = (state_nx == ST_RUN);
      done_nx = (state_nx == ST_DONE);
      we_nx   = 1'b0;
      ofs     = OFS_X;
      dout_nx = dout_q;
      case (phase_nx)
         3'd0: ofs = OFS_X;
         3'd1: ofs = OFS_Y;
         3'd5: begin ofs = OFS_X;   we_nx = busy_nx; dout_nx = ax_pos_nx[0]; end
         3'd6: begin ofs = OFS_Y;   we_nx = busy_nx; dout_nx = new_y;        end
         3'd7: begin ofs = OFS_VEL; we_nx = busy_nx; dout_nx = new_vel;      end
         default: ofs = OFS_VEL;
      endcase
      addr_nx = busy_nx ? {index_nx, ofs} : '0;
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.ram_we   = we_q;
   assign bus.ram_addr = addr_q;
   assign bus.ram_dout = dout_q;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Bench for sprite_motion_engine: RAM model, table-level motion model,
// directed corner entries plus random table contents.
module tb_sprite_motion_engine;
   import sprite_defs::*;

   localparam int         NB   = 5;
   localparam int         N    = 1 << NB;
   localparam logic [7:0] XMIN = 8'd16;
   localparam logic [7:0] XMAX = 8'd240;
   localparam logic [7:0] YMIN = 8'd0;
   localparam logic [7:0] YMAX = 8'd200;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic load = 1'b0;
   logic [7:0] mem [N*4];
   logic [7:0] img [N*4];
   logic [7:0] exp_mem [N*4];
   int we_cnt = 0, attr_we = 0, done_cnt = 0;
   int errors = 0, checks = 0;

   sprite_motion_engine_if #(.NB(NB)) bus ();

   sprite_motion_engine #(.NB(NB), .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // registered single-port sprite RAM, one cycle read latency
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < N*4; i++) mem[i] <= img[i];
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_dout;
      end
      bus.ram_din <= mem[bus.ram_addr];
   end

   always @(negedge clk) begin
      if (bus.ram_we) begin
         we_cnt <= we_cnt + 1;
         if (bus.ram_addr[1:0] == OFS_ATTR) attr_we <= attr_we + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, want);
      end
   endtask

   function automatic void axis_model(input logic [7:0] p, input logic [3:0] d, input int lo,
                                      input int hi, output logic [7:0] po, output logic [3:0] dn);
      int s, dv, nd;
      dv = $signed(d);
      s  = int'(p) + dv;
      nd = dv;
      if (s > hi) begin s = hi; nd = (dv == -8) ? 7 : -dv; end
      else if (s < lo) begin s = lo; nd = (dv == -8) ? 7 : -dv; end
      po = s[7:0];
      dn = nd[3:0];
   endfunction

   // apply one pass of motion to entries [0, upto)
   task automatic model_pass(input int upto);
      logic [7:0] nx, ny;
      logic [3:0] ndx, ndy;
      for (int i = 0; i < upto; i++) begin
         axis_model(exp_mem[i*4], exp_mem[i*4+3][7:4], XMIN, XMAX, nx, ndx);
         axis_model(exp_mem[i*4+1], exp_mem[i*4+3][3:0], YMIN, YMAX, ny, ndy);
         exp_mem[i*4]   = nx;
         exp_mem[i*4+1] = ny;
         exp_mem[i*4+3] = {ndx, ndy};
      end
   endtask

   task automatic cmp_table(input string pfx);
      for (int i = 0; i < N*4; i++)
         chk($sformatf("%s_mem%0d", pfx, i), mem[i], exp_mem[i]);
   endtask

   task automatic run_pass(input int mid_start, input string pfx);
      int lat, w0;
      lat = -1;
      w0  = we_cnt;
      @(posedge clk); #1 bus.start = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk); #1;
         if (n == 1) chk({pfx, "_busy_on"}, bus.busy, 1);
         bus.start = (n == mid_start);
         if (bus.done) begin lat = n; break; end
      end
      bus.start = 1'b0;
      chk({pfx, "_done_lat"}, lat, 257);
      @(posedge clk); #1;
      chk({pfx, "_done_pulse"}, bus.done, 0);
      chk({pfx, "_busy_off"}, bus.busy, 0);
      chk({pfx, "_we_cnt"}, we_cnt - w0, 96);
   endtask

   initial begin
      int w0, d0;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_we", bus.ram_we, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_dout", bus.ram_dout, 0);
      chk("rst_writes", we_cnt, 0);
      reset = 1'b0;

      for (int i = 0; i < N; i++) begin
         img[i*4]   = 8'($urandom_range(0, 255));
         img[i*4+1] = 8'($urandom_range(0, 255));
         img[i*4+2] = 8'hA5;
         img[i*4+3] = 8'($urandom);
      end
      img[0]  = 8'd100; img[1]  = 8'd50; img[3]  = 8'h21;
      img[4]  = 8'd239; img[5]  = 8'd50; img[7]  = 8'h30;
      img[8]  = 8'd100; img[9]  = 8'd2;  img[11] = 8'h0C;
      img[12] = XMIN;   img[13] = 8'd50; img[15] = 8'h80;
      img[16] = 8'd60;  img[17] = 8'd70; img[19] = 8'h00;
      img[20] = 8'd250; img[21] = 8'd220; img[23] = 8'h00;
      img[24] = 8'd250; img[25] = 8'd100; img[27] = 8'h70;
      for (int i = 0; i < N*4; i++) exp_mem[i] = img[i];
      @(posedge clk); #1 load = 1'b1;
      @(posedge clk); #1 load = 1'b0;

      run_pass(0, "p1");
      chk("e0_x", mem[0], 102);
      chk("e0_y", mem[1], 51);
      chk("e0_vel", mem[3], 8'h21);
      chk("e1_x", mem[4], 240);
      chk("e1_vel", mem[7], 8'hD0);
      chk("e1_y", mem[5], 50);
      chk("e2_y", mem[9], 0);
      chk("e2_vel", mem[11], 8'h04);
      chk("e3_x", mem[12], XMIN);
      chk("e3_vel", mem[15], 8'h70);
      chk("e4_same", {mem[16], mem[17], mem[19]}, {8'd60, 8'd70, 8'h00});
      chk("e5_clamp", {mem[20], mem[21]}, {XMAX, YMAX});
      chk("e6_nowrap", {mem[24], mem[27]}, {XMAX, 8'h90});
      model_pass(N);
      cmp_table("p1");

      run_pass(50, "p2");
      model_pass(N);
      cmp_table("p2");
      run_pass(0, "p3");
      model_pass(N);
      cmp_table("p3");
      chk("attr_writes", attr_we, 0);

      // reset partway through sprite 12's read phase
      w0 = we_cnt;
      d0 = done_cnt;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (99) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("mid_rst_we", bus.ram_we, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_done", bus.done, 0);
      repeat (300) @(posedge clk);
      #1;
      chk("mid_rst_nodone", done_cnt - d0, 0);
      chk("mid_rst_writes", we_cnt - w0, 36);
      model_pass(12);
      cmp_table("p4");

      bus.start = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      reset = 1'b0;
      chk("rst_wins_busy", bus.busy, 0);
      @(posedge clk); #1;
      chk("rst_wins_idle", bus.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=%0d exp=%0d", 1, 0);
      $fatal(1, "timeout");
   end
endmodule
